// File: rtl/me_search.sv
// me_search: full-search block-matching motion estimator. Buffers one current block and its
// reference window, scores one candidate offset per cycle and returns the best vector and SAD.
module me_search #(
  parameter int unsigned BLK        = 8,
  parameter int unsigned RANGE      = 16,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned EARLY_EXIT = 0,
  localparam int unsigned REF_W     = BLK + RANGE - 1,
  localparam int unsigned MV_W      = $clog2(RANGE),
  localparam int unsigned SAD_W     = PIX_W + 2 * $clog2(BLK)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cur_valid_i,
  output logic                     cur_ready_o,
  input  logic [BLK*PIX_W-1:0]     cur_data_i,
  input  logic                     ref_valid_i,
  output logic                     ref_ready_o,
  input  logic [REF_W*PIX_W-1:0]   ref_data_i,
  input  logic [SAD_W-1:0]         sad_thresh_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [MV_W-1:0]          mv_x_o,
  output logic [MV_W-1:0]          mv_y_o,
  output logic [SAD_W-1:0]         sad_o,
  output logic                     busy_o
);

  localparam int unsigned CUR_IW = $clog2(BLK);
  localparam int unsigned REF_IW = $clog2(REF_W);
  localparam logic [MV_W-1:0] MV_MAX = MV_W'(RANGE - 1);
  localparam logic [MV_W-1:0] MV_OFS = MV_W'(RANGE / 2);

  typedef enum logic [1:0] {LOAD, SEARCH, DONE} state_t;

  state_t                  state;
  logic [CUR_IW:0]         cur_cnt;
  logic [REF_IW:0]         ref_cnt;
  logic [BLK*PIX_W-1:0]    cur_rows [BLK];
  logic [REF_W*PIX_W-1:0]  ref_rows [REF_W];

  // candidate issue counters and the one-deep SAD pipeline stage
  logic [MV_W-1:0]         cx, cy;
  logic                    issuing;
  logic                    p_valid;
  logic [SAD_W-1:0]        p_sad;
  logic [MV_W-1:0]         p_cx, p_cy;
  logic [SAD_W-1:0]        best_sad;
  logic [MV_W-1:0]         best_cx, best_cy;
  logic [SAD_W-1:0]        thresh_q;

  logic                    cur_fire_c, ref_fire_c, load_done_c;
  logic [CUR_IW:0]         cur_cnt_nx_c;
  logic [REF_IW:0]         ref_cnt_nx_c;
  logic                    take_c, finish_c;
  logic [SAD_W-1:0]        sel_sad_c;
  logic [MV_W-1:0]         sel_cx_c, sel_cy_c;

  assign cur_fire_c   = cur_valid_i & cur_ready_o;
  assign ref_fire_c   = ref_valid_i & ref_ready_o;
  assign cur_cnt_nx_c = cur_cnt + (CUR_IW+1)'(cur_fire_c);
  assign ref_cnt_nx_c = ref_cnt + (REF_IW+1)'(ref_fire_c);
  assign load_done_c  = (cur_cnt_nx_c == (CUR_IW+1)'(BLK)) && (ref_cnt_nx_c == (REF_IW+1)'(REF_W));

  // candidate 0 always wins; later ones only on a strictly smaller SAD
  assign take_c    = ((p_cx == '0) && (p_cy == '0)) || (p_sad < best_sad);
  assign finish_c  = ((p_cx == MV_MAX) && (p_cy == MV_MAX)) ||
                     ((EARLY_EXIT != 0) && (p_sad <= thresh_q));
  assign sel_sad_c = take_c ? p_sad : best_sad;
  assign sel_cx_c  = take_c ? p_cx  : best_cx;
  assign sel_cy_c  = take_c ? p_cy  : best_cy;

  // SAD of candidate (cx, cy): window row r+cy shifted right by cx pixels lines up with cur row r
  logic [REF_W*PIX_W-1:0]  ref_row_c;
  logic [PIX_W-1:0]        cur_pix_c, ref_pix_c;
  logic [SAD_W-1:0]        sad_c;

  always_comb begin
    sad_c     = '0;
    ref_row_c = '0;
    cur_pix_c = '0;
    ref_pix_c = '0;
    for (int r = 0; r < BLK; r++) begin
      ref_row_c = ref_rows[REF_IW'(r) + REF_IW'(cy)] >> (int'(cx) * PIX_W);
      for (int k = 0; k < BLK; k++) begin
        cur_pix_c = cur_rows[r][k*PIX_W +: PIX_W];
        ref_pix_c = ref_row_c[k*PIX_W +: PIX_W];
        sad_c = sad_c + SAD_W'((cur_pix_c >= ref_pix_c) ? (cur_pix_c - ref_pix_c)
                                                        : (ref_pix_c - cur_pix_c));
      end
    end
  end

  // row storage; stale contents are harmless because the counters gate use
  always_ff @(posedge clk_i) begin
    if (cur_fire_c) cur_rows[cur_cnt[CUR_IW-1:0]] <= cur_data_i;
    if (ref_fire_c) ref_rows[ref_cnt[REF_IW-1:0]] <= ref_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= LOAD;
      cur_cnt     <= '0;
      ref_cnt     <= '0;
      cur_ready_o <= 1'b1;
      ref_ready_o <= 1'b1;
      res_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      mv_x_o      <= '0;
      mv_y_o      <= '0;
      sad_o       <= '0;
      cx          <= '0;
      cy          <= '0;
      issuing     <= 1'b0;
      p_valid     <= 1'b0;
      p_sad       <= '0;
      p_cx        <= '0;
      p_cy        <= '0;
      best_sad    <= '0;
      best_cx     <= '0;
      best_cy     <= '0;
      thresh_q    <= '0;
    end else begin
      case (state)
        LOAD: begin
          cur_cnt <= cur_cnt_nx_c;
          ref_cnt <= ref_cnt_nx_c;
          if (load_done_c) begin
            state       <= SEARCH;
            cur_ready_o <= 1'b0;
            ref_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            issuing     <= 1'b1;
            cx          <= '0;
            cy          <= '0;
            p_valid     <= 1'b0;
            thresh_q    <= sad_thresh_i;
          end else begin
            cur_ready_o <= (cur_cnt_nx_c < (CUR_IW+1)'(BLK));
            ref_ready_o <= (ref_cnt_nx_c < (REF_IW+1)'(REF_W));
          end
        end
        SEARCH: begin
          p_valid <= issuing;
          p_sad   <= sad_c;
          p_cx    <= cx;
          p_cy    <= cy;
          if (issuing) begin
            cx <= cx + MV_W'(1);
            if (cx == MV_MAX) cy <= cy + MV_W'(1);
            if ((cx == MV_MAX) && (cy == MV_MAX)) issuing <= 1'b0;
          end
          if (p_valid) begin
            best_sad <= sel_sad_c;
            best_cx  <= sel_cx_c;
            best_cy  <= sel_cy_c;
            if (finish_c) begin
              state       <= DONE;
              issuing     <= 1'b0;
              res_valid_o <= 1'b1;
              mv_x_o      <= sel_cx_c - MV_OFS;
              mv_y_o      <= sel_cy_c - MV_OFS;
              sad_o       <= sel_sad_c;
            end
          end
        end
        DONE: begin
          if (res_ready_i) begin
            state       <= LOAD;
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            cur_cnt     <= '0;
            ref_cnt     <= '0;
            cur_ready_o <= 1'b1;
            ref_ready_o <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
